sync_det: RTL and testbench

Video timing receiver and analyzer: the receiving end of the HS/VS/DE raster produced by the display sync generator. It samples an incoming 16-bit video stream with its sync strobes, recovers per-pixel coordinates, and measures horizontal and vertical totals and active sizes. It declares lock once two consecutive frames measure identically. It sits between a capture/loopback source and the DDR write path, which uses `pos_x`/`pos_y`, `sof` and `locked` to place pixels.

---
 rtl/sync_det.sv | 121 ++++++++++++
 tb/tb_sync_det.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sync_det.sv
// sync_det: video timing receiver; recovers pixel coordinates, measures raster timing, declares lock (watchdog under SYNC_DET_TIMEOUT_EN)
module sync_det #(
  parameter int          X_BITS  = 12,
  parameter int          Y_BITS  = 12,
  parameter logic [23:0] TIMEOUT = 24'd4_000_000
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [15:0]       data_in,
  output logic              de_out,
  output logic [15:0]       data_out,
  output logic [X_BITS-1:0] pos_x,
  output logic [Y_BITS-1:0] pos_y,
  output logic              sof,
  output logic [X_BITS-1:0] h_total,
  output logic [X_BITS-1:0] h_act,
  output logic [Y_BITS-1:0] v_total,
  output logic [Y_BITS-1:0] v_act,
  output logic              locked
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  localparam int MW = 2 * X_BITS + 2 * Y_BITS;
  state_t state;
  logic vs1, vs2, hs1, hs2, de1, de2;
  logic [15:0] d1;
  logic [X_BITS-1:0] hc, ac, lt, la, px, lt_n, la_n;
  logic [Y_BITS-1:0] vc, vac, py, vc_n, vac_n;
  logic first_de, vs_rise, hs_rise, de_fall, match;
  logic [MW-1:0] meas, ref_m;
  // Edge strobes and the frame measurement as it stands including this cycle's edges
  always_comb begin
    vs_rise = vs1 & ~vs2;
    hs_rise = hs1 & ~hs2;
    de_fall = ~de1 & de2;
    lt_n    = hs_rise ? hc : lt;
    la_n    = de_fall ? ac : la;
    vc_n    = vc + Y_BITS'(hs_rise && !(&vc));
    vac_n   = vac + Y_BITS'(de_fall && !(&vac));
    meas    = {lt_n, la_n, vc_n, vac_n};
    match   = meas == ref_m;
  end
  // Two-stage input pipeline; outputs are the second stage
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {vs1, vs2, hs1, hs2, de1, de2, de_out} <= '0;
      d1       <= '0;
      data_out <= '0;
    end else begin
      {vs1, hs1, de1} <= {vs_in, hs_in, de_in};
      {vs2, hs2, de2} <= {vs1, hs1, de1};
      d1       <= data_in;
      de_out   <= de1;
      data_out <= d1;
    end
  // Line and frame counters; all saturate instead of wrapping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {hc, ac, lt, la} <= '0;
      {vc, vac}        <= '0;
    end else begin
      hc  <= hs_rise ? X_BITS'(1) : (&hc ? hc : hc + 1'b1);
      ac  <= de_fall ? '0 : (de1 && !(&ac) ? ac + 1'b1 : ac);
      lt  <= lt_n;
      la  <= la_n;
      vc  <= vs_rise ? '0 : vc_n;
      vac <= vs_rise ? '0 : vac_n;
    end
  // Pixel coordinates and start-of-frame, registered alongside de_out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {px, pos_x}     <= '0;
      {py, pos_y}     <= '0;
      {first_de, sof} <= '0;
    end else begin
      px       <= de_fall ? '0 : (de1 ? px + 1'b1 : px);
      py       <= vs_rise ? '0 : (de_fall ? py + 1'b1 : py);
      first_de <= vs_rise | (first_de & ~de1);
      pos_x    <= de1 ? px : pos_x;
      pos_y    <= de1 ? (vs_rise ? '0 : py) : pos_y;
      sof      <= de1 && (first_de || vs_rise) && px == '0 && (vs_rise || py == '0);
    end
`ifdef SYNC_DET_TIMEOUT_EN
  logic [23:0] wd;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif
  // Lock FSM, stepped on VS rising edges; a mismatch refreshes the reference and re-measures
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= SEARCH;
      locked <= 1'b0;
      ref_m  <= '0;
      {h_total, h_act, v_total, v_act} <= '0;
`ifdef SYNC_DET_TIMEOUT_EN
      wd     <= '0;
`endif
    end else begin
`ifdef SYNC_DET_TIMEOUT_EN
      wd <= vs_rise ? '0 : (wd == TIMEOUT ? wd : wd + 24'd1);
      if (wd == TIMEOUT && !vs_rise) begin
        state  <= SEARCH;
        locked <= 1'b0;
        ref_m  <= '0;
        {h_total, h_act, v_total, v_act} <= '0;
      end else
`endif
      if (vs_rise) begin
        if (state == SEARCH) state <= MEASURE;
        else begin
          ref_m  <= meas;
          state  <= match ? LOCKED : MEASURE;
          locked <= match;
          if (match) {h_total, h_act, v_total, v_act} <= meas;
        end
      end
    end
endmodule

// File: tb/tb_sync_det.sv
// tb_sync_det: directed raster frames with a pixel scoreboard for sync_det
module tb_sync_det;
  logic clk = 0, rst = 1, vs_in = 0, hs_in = 0, de_in = 0;
  logic [15:0] data_in = '0;
  logic de_out, sof, locked;
  logic [15:0] data_out;
  logic [11:0] pos_x, pos_y, h_total, h_act, v_total, v_act;
  int checks = 0, failures = 0, pix = 0;
  bit seen_vs = 0;
  logic [40:0] q[$];

  sync_det #(.X_BITS(12), .Y_BITS(12), .TIMEOUT(24'd500)) dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .data_in(data_in),
    .de_out(de_out), .data_out(data_out), .pos_x(pos_x), .pos_y(pos_y), .sof(sof),
    .h_total(h_total), .h_act(h_act), .v_total(v_total), .v_act(v_act), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic meas(input string tag, input logic l, input int ht, input int ha, input int vt, input int va);
    chk({tag, "_locked"}, locked, l);
    chk({tag, "_h_total"}, h_total, ht);
    chk({tag, "_h_act"}, h_act, ha);
    chk({tag, "_v_total"}, v_total, vt);
    chk({tag, "_v_act"}, v_act, va);
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {de_out, data_out, pos_x, pos_y, sof, h_total, h_act, v_total, v_act, locked}, '0);
  endtask

  // 20 clocks per line, HS on clocks 0-1, DE from clock 4 on lines 0-5, VS on lines 8-9
  task automatic frame(input int act, input int rst_at);
    for (int l = 0; l < 10; l++)
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (l == 0 && c == 0) pix = 0;
        hs_in = c < 2;
        vs_in = l >= 8;
        de_in = l < 6 && c >= 4 && c < 4 + act;
        if (de_in) begin
          data_in = 16'(pix);
          q.push_back({16'(pix), 12'(c - 4), 12'(l), seen_vs && l == 0 && c == 4});
          pix++;
        end
        if (l == 8 && c == 0) seen_vs = 1;
        if (l * 20 + c == rst_at) begin
          rst = 1;
          @(negedge clk);
          all_zero("midframe_rst_outs");
          rst = 0;
          seen_vs = 0;
        end
      end
  endtask

  task automatic sat_line(input logic v);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      hs_in = c == 0;
      vs_in = v;
      de_in = 0;
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (de_out) begin
        int n;
        logic [40:0] e;
        n = q.size();
        chk("pix_avail", n != 0, 1'b1);
        e = n != 0 ? q.pop_front() : '0;
        chk("pixel", {data_out, pos_x, pos_y, sof}, e);
      end else chk("sof_idle", sof, 1'b0);
    end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    all_zero("reset_outs");
    @(posedge clk); #1 rst = 0;
    frame(12, -1);
    frame(12, -1);
    meas("pre_lock", 0, 0, 0, 0, 0);
    frame(12, -1);
    meas("lock", 1, 20, 12, 10, 6);
    frame(10, -1);
    meas("unlock", 0, 20, 12, 10, 6);
    frame(10, -1);
    frame(10, -1);
    meas("relock", 1, 20, 10, 10, 6);
    frame(10, 150);
    meas("rst_edge1", 0, 0, 0, 0, 0);
    frame(10, -1);
    meas("rst_edge2", 0, 0, 0, 0, 0);
    frame(10, -1);
    meas("rst_relock", 1, 20, 10, 10, 6);
`ifdef SYNC_DET_TIMEOUT_EN
    vs_in = 0;
    repeat (410) @(posedge clk);
    @(negedge clk);
    meas("wd_hold", 1, 20, 10, 10, 6);
    repeat (110) @(posedge clk);
    @(negedge clk);
    meas("wd_drop", 0, 0, 0, 0, 0);
`else
    rst = 1;
    @(posedge clk); #1 rst = 0;
    seen_vs = 0;
    sat_line(1);
    repeat (2000) sat_line(0);
    @(negedge clk);
    chk("sat_no_lock", locked, 1'b0);
    repeat (2199) sat_line(0);
    sat_line(1);
    repeat (4199) sat_line(0);
    sat_line(1);
    repeat (3) sat_line(0);
    @(negedge clk);
    meas("sat", 1, 4, 0, 4095, 0);
`endif
    chk("q_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
